// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit hex display driver for Basys3. New words are
// held pending and swapped in only at a frame boundary; LEDs mirror the word.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] din,
  input  logic [3:0]  din_dp,
  input  logic        din_valid,
  input  logic        blank_lz,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic [15:0] led,
  output logic        upd_ack
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);
  localparam logic [7:0] SEG_OFF = {8{ACTIVE_LOW}};
  localparam logic [3:0] AN_OFF = {4{ACTIVE_LOW}};

  logic [PW-1:0] presc;
  logic [1:0]    digit_idx;
  logic          pending;
  logic [15:0]   pend_val;
  logic [3:0]    pend_dp;
  logic [15:0]   shown;
  logic [3:0]    shown_dp;
  logic          tick;
  logic          frame_end;
  logic          blank;
  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic [7:0]    seg_next;
  logic [3:0]    an_next;

  assign tick      = (presc == LAST);
  assign frame_end = tick && (digit_idx == 2'd3);
  assign nibble    = shown[{digit_idx, 2'b00} +: 4];

  // Digit 0 always shows, so a zero word still reads "0".
  assign blank = blank_lz && (digit_idx != 2'd0) &&
                 ((shown >> {digit_idx, 2'b00}) == 16'd0);

  always_comb begin
    glyph = 7'h00;
    unique case (nibble)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      4'hF: glyph = 7'h71;
    endcase
  end

  assign seg_next = (blank ? 8'h00 : {shown_dp[digit_idx], glyph}) ^ SEG_OFF;
  assign an_next  = (4'b0001 << digit_idx) ^ AN_OFF;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc     <= '0;
      digit_idx <= 2'd0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) digit_idx <= digit_idx + 2'd1;
    end
  end

  // A strobe on the swap cycle queues behind the word being applied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= 1'b0;
      pend_val <= 16'd0;
      pend_dp  <= 4'd0;
      shown    <= 16'd0;
      shown_dp <= 4'd0;
      upd_ack  <= 1'b0;
    end else begin
      upd_ack <= frame_end && pending;
      if (frame_end && pending) begin
        shown    <= pend_val;
        shown_dp <= pend_dp;
      end
      if (din_valid) begin
        pend_val <= din;
        pend_dp  <= din_dp;
        pending  <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
      led <= 16'd0;
    end else begin
      seg <= seg_next;
      an  <= an_next;
      led <= shown;
    end
  end
endmodule
